// File: rtl/exec_muldiv_pkg.sv
// exec_muldiv_pkg -- shared definitions for the EX-stage multiply/divide unit.
//   Op encodings (MD_MULT..MD_MSUB), FSM state type and constants,
//   divide-by-zero result constant and small op-classification helpers.
//   MULDIV_MADD_EN: when defined, MADD/MSUB are legal opcodes.
package exec_muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MADD  = 3'd4;
  localparam logic [2:0] MD_MSUB  = 3'd5;

  typedef logic [2:0] md_state_t;

  localparam md_state_t ST_IDLE = 3'd0;
  localparam md_state_t ST_MUL  = 3'd1;
  localparam md_state_t ST_DIV  = 3'd2;
  localparam md_state_t ST_DIVZ = 3'd3;
  localparam md_state_t ST_DONE = 3'd4;

  // Divide by zero: HI returns the dividend, LO is this bit replicated.
  localparam logic DIVZ_LO_BIT = 1'b1;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

  function automatic logic op_supported(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return op <= MD_MSUB;
`else
    return op <= MD_DIVU;
`endif
  endfunction

endpackage

// File: rtl/exec_muldiv_div_core.sv
// md_div_core -- restoring radix-2 divider on unsigned magnitudes.
//   One quotient bit per cycle, WIDTH iterations after start.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              load dividend/divisor and begin iterating
//   abort              drop the division in progress
//   dividend, divisor  unsigned magnitudes (divisor must be non-zero)
//   done               high during the final iteration; quotient/remainder
//                      hold the final values from the following cycle on
//   quotient, remainder
module md_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The quotient register doubles as the dividend shift register.
  assign shifted = {remainder, quotient[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvsr_q};
  assign done    = running & (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      running   <= 1'b0;
      cnt       <= '0;
      dvsr_q    <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running   <= 1'b1;
      cnt       <= CW'(WIDTH - 1);
      dvsr_q    <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (running) begin
      // Borrow out of the trial subtraction means restore.
      if (diff[WIDTH]) begin
        remainder <= shifted[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end else begin
        remainder <= diff[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end
      cnt <= cnt - CW'(1);
      if (cnt == '0) running <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// exec_muldiv -- multi-cycle multiply/divide unit beside the EX-stage ALU.
//   Runs MULT/MULTU/DIV/DIVU (and MADD/MSUB when MULDIV_MADD_EN is defined),
//   stalls IF/ID/EX until the {HI,LO} result is ready, then strobes it for
//   one cycle toward MEM.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_in            EX holds a mul/div op (held high while stalled)
//   op_in               opcode, see exec_muldiv_pkg
//   src1_in, src2_in    rs / rt operands
//   hilo_in             forwarded {HI,LO}, accumulator for MADD/MSUB
//   annul_in            flush: abandon the op in flight
//   stall_req           pipeline hold
//   busy                FSM not idle
//   whilo_out           one-cycle strobe, hi_out/lo_out valid
//   hi_out, lo_out      product high/low, or remainder/quotient
//
// state | meaning
// IDLE  | waiting for start_in with a supported op
// MUL   | product travelling down the MUL_LAT-deep pipeline
// DIV   | md_div_core iterating
// DIVZ  | divide by zero, fixed result next cycle
// DONE  | result on hi_out/lo_out, whilo_out high
module exec_muldiv
  import exec_muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [2:0]         op_in,
  input  logic [WIDTH-1:0]   src1_in,
  input  logic [WIDTH-1:0]   src2_in,
  input  logic [2*WIDTH-1:0] hilo_in,
  input  logic               annul_in,
  output logic               stall_req,
  output logic               busy,
  output logic               whilo_out,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);

  localparam int DW = 2 * WIDTH;

  md_state_t        state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [DW-1:0]    res_q;
  logic [DW-1:0]    pipe [MUL_LAT];
  logic [7:0]       mul_cnt;
  logic             accept, div_start, div_done;
  logic [DW-1:0]    prod_in, mul_acc, result;
  logic [WIDTH-1:0] div_q, div_r, q_fix, r_fix;

  function automatic logic [DW-1:0] ext(input logic [WIDTH-1:0] v, input logic sgn);
    return {{WIDTH{sgn & v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn & v[WIDTH-1]) ? -v : v;
  endfunction

  assign accept    = ~rst & ~annul_in & (state_q == ST_IDLE) & start_in & op_supported(op_in);
  assign div_start = accept & is_div_op(op_in) & (src2_in != '0);
  assign prod_in   = ext(src1_in, is_signed_op(op_in)) * ext(src2_in, is_signed_op(op_in));

  assign stall_req = accept | (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_DIVZ);
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && annul_in) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          if (is_mul_op(op_in))    state_d = ST_MUL;
          else if (src2_in == '0)  state_d = ST_DIVZ;
          else                     state_d = ST_DIV;
        end
        ST_MUL:  if (mul_cnt == '0) state_d = ST_DONE;
        ST_DIV:  if (div_done)      state_d = ST_DONE;
        ST_DIVZ: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      mul_cnt <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_in;
        s1_q    <= src1_in;
        s2_q    <= src2_in;
        mul_cnt <= 8'(MUL_LAT - 1);
      end else if (state_q == ST_MUL && mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 8'd1;
      end
      if (state_q == ST_MUL && mul_cnt == '0) res_q <= mul_acc;
    end
  end

  // Product enters stage 0 on accept and shifts every cycle; the counter
  // guarantees it has reached the last stage when it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '{default: '0};
    end else begin
      if (accept) pipe[0] <= prod_in;
      for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

`ifdef MULDIV_MADD_EN
  logic [DW-1:0] hilo_q;

  always_ff @(posedge clk) begin
    if (rst)         hilo_q <= '0;
    else if (accept) hilo_q <= hilo_in;
  end

  always_comb begin
    case (op_q)
      MD_MADD: mul_acc = hilo_q + pipe[MUL_LAT-1];
      MD_MSUB: mul_acc = hilo_q - pipe[MUL_LAT-1];
      default: mul_acc = pipe[MUL_LAT-1];
    endcase
  end
`else
  logic unused_hilo;
  assign unused_hilo = ^hilo_in;
  assign mul_acc     = pipe[MUL_LAT-1];
`endif

  md_div_core #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (annul_in),
    .dividend  (mag(src1_in, is_signed_op(op_in))),
    .divisor   (mag(src2_in, is_signed_op(op_in))),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Signed divide: quotient negative iff signs differ, remainder follows
  // the dividend. Most-negative / -1 falls out as most-negative, rem 0.
  always_comb begin
    q_fix = div_q;
    r_fix = div_r;
    if (op_q == MD_DIV) begin
      if (s1_q[WIDTH-1] ^ s2_q[WIDTH-1]) q_fix = -div_q;
      if (s1_q[WIDTH-1])                 r_fix = -div_r;
    end
  end

  always_comb begin
    if (is_mul_op(op_q))    result = res_q;
    else if (s2_q == '0)    result = {s1_q, {WIDTH{DIVZ_LO_BIT}}};
    else                    result = {r_fix, q_fix};
  end

  assign whilo_out        = (state_q == ST_DONE) & ~annul_in;
  assign {hi_out, lo_out} = whilo_out ? result : '0;

endmodule

// File: tb/tb_exec_muldiv.sv
// tb_exec_muldiv -- self-checking bench for exec_muldiv (WIDTH=32, MUL_LAT=3).
//   Directed cases plus random ops checked against an arithmetic model.
//   Honours MULDIV_MADD_EN for the expected behaviour of ops 4/5.
module tb_exec_muldiv;

  localparam int W   = 32;
  localparam int LAT = 3;
`ifdef MULDIV_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start_in, annul_in;
  logic [2:0]    op_in;
  logic [W-1:0]  src1_in, src2_in;
  logic [63:0]   hilo_in;
  logic          stall_req, busy, whilo_out;
  logic [W-1:0]  hi_out, lo_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exec_muldiv #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .op_in(op_in),
    .src1_in(src1_in), .src2_in(src2_in), .hilo_in(hilo_in), .annul_in(annul_in),
    .stall_req(stall_req), .busy(busy), .whilo_out(whilo_out),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit / 32-bit arithmetic on the architectural rules.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] hilo, output bit ok, output int lat,
                                output logic [63:0] res);
    longint sp;
    int     q, r;
    ok  = 1'b1;
    lat = 0;
    res = '0;
    sp  = longint'($signed(a)) * longint'($signed(b));
    case (op)
      3'd0: begin res = sp; lat = LAT + 1; end
      3'd1: begin res = {32'b0, a} * {32'b0, b}; lat = LAT + 1; end
      3'd2, 3'd3: begin
        if (b == 0) begin
          res = {a, 32'hFFFF_FFFF};
          lat = 2;
        end else begin
          lat = W + 1;
          if (op == 3'd3) res = {a % b, a / b};
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
          else begin
            q   = $signed(a) / $signed(b);
            r   = $signed(a) % $signed(b);
            res = {r, q};
          end
        end
      end
      3'd4, 3'd5: begin
        if (!MADD_ON) ok = 1'b0;
        else begin
          res = (op == 3'd4) ? hilo + 64'(sp) : hilo - 64'(sp);
          lat = LAT + 1;
        end
      end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] hilo, input int annul_at);
    bit          ok, seen;
    int          lat;
    logic [63:0] res;
    model(op, a, b, hilo, ok, lat, res);
    seen = 1'b0;
    @(negedge clk);
    start_in = 1'b1; op_in = op; src1_in = a; src2_in = b; hilo_in = hilo; annul_in = 1'b0;
    #1 check("stall_accept", 64'(stall_req), 64'(ok));
    if (!ok) begin
      start_in = 1'b0;
      repeat (6) begin
        @(negedge clk);
        #1 check("unknown_idle", {busy, whilo_out, stall_req}, 64'd0);
      end
      return;
    end
    for (int cyc = 1; cyc <= W + 8 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == annul_at) begin
        annul_in = 1'b1; start_in = 1'b0;
        #1 check("annul_nostrobe", 64'(whilo_out), 64'd0);
        @(negedge clk);
        annul_in = 1'b0;
        #1 check("annul_busy", 64'(busy), 64'd0);
        repeat (40) begin
          @(negedge clk);
          #1 check("annul_quiet", {busy, whilo_out}, 64'd0);
        end
        return;
      end
      #1;
      if (whilo_out) begin
        seen = 1'b1;
        check("latency", 64'(cyc), 64'(lat));
        check("result", {hi_out, lo_out}, res);
        check("stall_done", 64'(stall_req), 64'd0);
        start_in = 1'b0;
      end else begin
        check("stall_wait", 64'(stall_req), 64'd1);
      end
    end
    if (!seen) check("strobe_seen", 64'd0, 64'd1);
    @(negedge clk);
    #1 check("post_idle", {busy, whilo_out, stall_req, hi_out, lo_out}, 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start_in = 1'b1; op_in = 3'd0; annul_in = 1'b0;
    src1_in = 32'd3; src2_in = 32'd5; hilo_in = '0;
    repeat (3) @(negedge clk);
    #1 check("reset_outputs", {stall_req, busy, whilo_out, hi_out, lo_out}, 64'd0);
    start_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_idle", {busy, whilo_out}, 64'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0, -1);
    run_op(3'd3, 32'd100, 32'd7, 64'd0, -1);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, -1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, -1);
    run_op(3'd2, 32'd5, 32'd0, 64'd0, -1);
    run_op(3'd3, 32'd1000, 32'd3, 64'd0, 10);
    run_op(3'd1, 32'd2, 32'd3, 64'd0, -1);
    run_op(3'd4, 32'd1, 32'd1, {32'd0, 32'hFFFF_FFFF}, -1);
    run_op(3'd5, 32'd7, 32'hFFFF_FFFE, 64'd100, -1);
    run_op(3'd6, 32'd1, 32'd1, 64'd0, -1);
    run_op(3'd7, 32'd1, 32'd1, 64'd0, -1);
    run_op(3'd0, 32'd9, 32'd9, 64'd0, 2);

    // Flush together with start in IDLE: nothing accepted.
    @(negedge clk);
    start_in = 1'b1; op_in = 3'd0; annul_in = 1'b1;
    #1 check("annul_idle_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start_in = 1'b0; annul_in = 1'b0;
    #1 check("annul_idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 60; i++)
      run_op(3'($urandom_range(0, 7)), pick(), pick(), {$urandom, $urandom}, -1);

    // Synchronous reset in the middle of a multiply.
    @(negedge clk);
    start_in = 1'b1; op_in = 3'd0; src1_in = 32'd4; src2_in = 32'd4;
    @(negedge clk);
    start_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_midop", {busy, whilo_out, stall_req}, 64'd0);
    repeat (6) begin
      @(negedge clk);
      #1 check("rst_quiet", {busy, whilo_out}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
